regfile_wr_arbiter: RTL
=======================

Name: regfile_wr_arbiter

Overview:
- Shares the single register-file write port (RegWrite/WriteReg/WriteData) among NUM_REQ writeback requesters in the multi-cycle core, e.g. ALU, load unit and CSR unit.
- Arbitrates round-robin with a valid/ready handshake per requester.
- Registers the winning request and drives the register-file write port one cycle later.
- Drops writes to x0 and counts committed writes.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
AW, 5, register address width
DW, 32, data width
CNT_W, 16, width of committed-write counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
hold  in  1  controller stall; no grants while high
req_valid  in  NUM_REQ  per-requester write request
req_addr  in  NUM_REQ*AW  flattened; requester i at [i*AW +: AW]
req_data  in  NUM_REQ*DW  flattened; requester i at [i*DW +: DW]
req_ready  out  NUM_REQ  one-hot grant (combinational); transfer when valid&ready
RegWrite  out  1  register-file write enable (registered)
WriteReg  out  AW  register-file write address (registered)
WriteData  out  DW  register-file write data (registered)
busy  out  1  any req_valid high, or RegWrite high this cycle
wr_count  out  CNT_W  number of committed non-x0 writes

Behaviour:
- Reset (async, rst_n=0):
  - RegWrite=0, WriteReg=0, WriteData=0, wr_count=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready=0 while rst_n=0.
- Grant:
  - When hold=0, req_ready is the first i with req_valid[i]=1, scanning from rr_ptr upward and wrapping NUM_REQ-1 -> 0.
  - At most one bit set; all zero if no valid or hold=1.
- Pointer: on a transfer by requester g, rr_ptr <= (g==NUM_REQ-1) ? 0 : g+1. Otherwise unchanged.
- Output stage, updated every cycle:
  - On transfer with req_addr[g]!=0: RegWrite<=1, WriteReg<=req_addr[g], WriteData<=req_data[g].
  - On transfer with req_addr[g]==0: the request is accepted (ready=1) but RegWrite<=0; WriteReg/WriteData hold.
  - No transfer: RegWrite<=0; WriteReg/WriteData hold their last value.
- Latency: exactly one cycle from handshake to RegWrite=1. The register file writes on the following edge, so data is readable two edges after the handshake.
- Requester protocol:
  - Once asserted, req_valid/addr/data stay stable until the handshake.
  - The arbiter does not depend on this for correctness; it only samples the values at the handshake.
- wr_count increments by 1 on each cycle RegWrite=1 (a committed write) and wraps to 0 at 2^CNT_W-1+1.
- Same address from two requesters in one cycle: only the granted one is written; the other waits. Order follows grant order.
- hold rising while requests are pending: grants stop that cycle; a write already registered still completes.
- Reset mid-operation: the pending registered write is discarded (RegWrite forced 0 asynchronously).

Optional Feature:
- Macro REGFILE_WR_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; lowest index wins; rr_ptr is removed (tied to 0).
- Undefined: round-robin as above.
- All other behaviour is identical in both builds.

Decomposition:
- Package regfile_arb_pkg holds:
  - Constants REG_AW=5, REG_DW=32, REG_ZERO='0.
  - Typedef wr_req_t {logic [REG_AW-1:0] addr; logic [REG_DW-1:0] data;}.
- One natural sub-module: rr_arbiter, a generic NUM_REQ round-robin/fixed-priority grant generator with pointer update.
- regfile_wr_arbiter instantiates rr_arbiter and adds the output register, the x0 filter and the counter.

Test Plan:
- Reset: assert rst_n=0 mid-write (RegWrite=1) -> RegWrite=0, wr_count=0 immediately, with no clock edge needed.
- Single requester: req0 valid, addr=5, data=0xDEADBEEF -> req_ready=001 that cycle; next cycle RegWrite=1, WriteReg=5, WriteData=0xDEADBEEF; wr_count=1 after that edge.
- Round-robin: all three valid continuously with distinct addrs 1,2,3 -> grants 0,1,2,0... with one transfer per cycle; fixed-priority build -> grant stays 0.
- x0 drop: req1 valid, addr=0, data=0x1234 -> req_ready[1]=1; next cycle RegWrite=0; wr_count unchanged.
- hold: req0, req2 valid with hold=1 for 3 cycles -> req_ready=000, RegWrite=0; release hold -> grant req0, then req2 the next cycle.
- Counter wrap (CNT_W=4): 17 committed writes -> wr_count=1.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// ============================================================================
// Module   : regfile_arb_pkg
// Brief    : Shared constants and request type for the register-file write arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_arb_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } wr_req_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Generic NUM_REQ grant generator; round-robin, or fixed priority
//            (lowest index wins) when REGFILE_WR_ARB_FIXED_PRIO_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [PW-1:0]      grant_idx
);

  logic [PW-1:0] w_ptr;
  logic [PW:0]   w_scan;
  logic          w_found;

`ifdef REGFILE_WR_ARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [PW-1:0] r_ptr;

  // Pointer moves just past the winner so it gets lowest priority next time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (|grant) begin
      r_ptr <= (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  assign w_ptr = r_ptr;
`endif

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_scan    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_scan = {1'b0, w_ptr} + (PW+1)'(k);
      if (w_scan >= (PW+1)'(NUM_REQ)) begin
        w_scan = w_scan - (PW+1)'(NUM_REQ);
      end
      if (!w_found && req[w_scan[PW-1:0]]) begin
        w_found                = 1'b1;
        grant[w_scan[PW-1:0]]  = 1'b1;
        grant_idx              = w_scan[PW-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
// ============================================================================
// Module   : regfile_wr_arbiter
// Brief    : Shares the register-file write port among NUM_REQ writeback units,
//            drops x0 writes and counts commits. Macro REGFILE_WR_ARB_FIXED_PRIO_EN
//            selects fixed priority instead of round-robin.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int AW      = REG_AW,
  parameter int DW      = REG_DW,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hold,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  RegWrite,
  output logic [AW-1:0]         WriteReg,
  output logic [DW-1:0]         WriteData,
  output logic                  busy,
  output logic [CNT_W-1:0]      wr_count
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] w_req;
  logic [PW-1:0]      w_gidx;
  logic               w_xfer;
  logic [AW-1:0]      w_addr;
  logic [DW-1:0]      w_data;

  logic               r_we;
  logic [AW-1:0]      r_waddr;
  logic [DW-1:0]      r_wdata;
  logic [CNT_W-1:0]   r_cnt;

  // Masking with rst_n keeps ready low throughout reset.
  assign w_req = (rst_n && !hold) ? req_valid : '0;

  rr_arbiter #(
    .NUM_REQ   (NUM_REQ)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (w_req),
    .grant     (req_ready),
    .grant_idx (w_gidx)
  );

  assign w_xfer = |req_ready;
  assign w_addr = req_addr[w_gidx*AW +: AW];
  assign w_data = req_data[w_gidx*DW +: DW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
    end else begin
      r_we <= 1'b0;
      // x0 writes are accepted but never reach the port.
      if (w_xfer && (w_addr != AW'(REG_ZERO))) begin
        r_we    <= 1'b1;
        r_waddr <= w_addr;
        r_wdata <= w_data;
      end
      if (r_we) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign RegWrite  = r_we;
  assign WriteReg  = r_waddr;
  assign WriteData = r_wdata;
  assign wr_count  = r_cnt;
  assign busy      = (|req_valid) | r_we;

endmodule

`default_nettype wire
